// File: rtl/baud_rate_generator.sv
// UART oversampling tick generator: one-clk strobe every DIV(sel) cycles, divisor chosen at run time.
// Optional bit_tick output (every OVERSAMPLE-th tick) when BAUDGEN_BITTICK_EN is defined.
module baud_rate_generator #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned BAUD0      = 2400,
  parameter int unsigned BAUD1      = 4800,
  parameter int unsigned BAUD2      = 9600,
  parameter int unsigned BAUD3      = 19200
) (
  input  logic [1:0] sel,
  input  logic       clk,
  input  logic       rstn,
  output logic       tick
`ifdef BAUDGEN_BITTICK_EN
  ,
  output logic       bit_tick
`endif
);

  localparam int unsigned DIV0 = (CLK_HZ + BAUD0 * OVERSAMPLE / 2) / (BAUD0 * OVERSAMPLE);
  localparam int unsigned DIV1 = (CLK_HZ + BAUD1 * OVERSAMPLE / 2) / (BAUD1 * OVERSAMPLE);
  localparam int unsigned DIV2 = (CLK_HZ + BAUD2 * OVERSAMPLE / 2) / (BAUD2 * OVERSAMPLE);
  localparam int unsigned DIV3 = (CLK_HZ + BAUD3 * OVERSAMPLE / 2) / (BAUD3 * OVERSAMPLE);

  localparam int unsigned MAX01  = (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int unsigned MAX23  = (DIV2 > DIV3) ? DIV2 : DIV3;
  localparam int unsigned MAXDIV = (MAX01 > MAX23) ? MAX01 : MAX23;
  localparam int          CW     = $clog2(MAXDIV);

  if (DIV0 < 2 || DIV1 < 2 || DIV2 < 2 || DIV3 < 2) begin : g_div_check
    $error("baud_rate_generator: every divisor must be at least 2");
  end

  logic [CW-1:0] cnt;
  logic [CW-1:0] div_m1;
  logic [1:0]    sel_q;
  logic          run;
  logic          wrap;

  always_comb begin
    div_m1 = CW'(DIV0 - 1);
    case (sel_q)
      2'b00: div_m1 = CW'(DIV0 - 1);
      2'b01: div_m1 = CW'(DIV1 - 1);
      2'b10: div_m1 = CW'(DIV2 - 1);
      2'b11: div_m1 = CW'(DIV3 - 1);
      default: div_m1 = CW'(DIV0 - 1);
    endcase
  end

  assign wrap = run && (sel == sel_q) && (cnt == div_m1);

  // The first edge after reset adopts sel as part of the first period, so the
  // first tick lands on edge DIV(sel) rather than one later.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      cnt   <= '0;
      tick  <= 1'b0;
      sel_q <= 2'b00;
      run   <= 1'b0;
    end else if (!run) begin
      run   <= 1'b1;
      sel_q <= sel;
      cnt   <= CW'(1);
      tick  <= 1'b0;
    end else if (sel != sel_q) begin
      sel_q <= sel;
      cnt   <= '0;
      tick  <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

`ifdef BAUDGEN_BITTICK_EN
  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      tcnt     <= '0;
      bit_tick <= 1'b0;
    end else if (!run || (sel != sel_q)) begin
      tcnt     <= '0;
      bit_tick <= 1'b0;
    end else if (wrap) begin
      if (tcnt == TW'(OVERSAMPLE - 1)) begin
        tcnt     <= '0;
        bit_tick <= 1'b1;
      end else begin
        tcnt     <= tcnt + TW'(1);
        bit_tick <= 1'b0;
      end
    end else begin
      bit_tick <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_baud_rate_generator.sv
// Bench for baud_rate_generator: tick timing measured in clock edges against divisors
// derived from the baud-rate arithmetic, with randomized select changes and reset points.
module tb_baud_rate_generator;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] sel;
  logic       tick;
`ifdef BAUDGEN_BITTICK_EN
  logic       bit_tick;
`endif

  int total = 0;
  int bad   = 0;
  int bt_at_tick = 0;
  int bt_stray   = 0;

  baud_rate_generator dut (
    .sel  (sel),
    .clk  (clk),
    .rstn (rstn),
    .tick (tick)
`ifdef BAUDGEN_BITTICK_EN
    ,
    .bit_tick (bit_tick)
`endif
  );

  always #5 clk = ~clk;

  function automatic int ref_div(input logic [1:0] s);
    int baud;
    case (s)
      2'b00:   baud = 2400;
      2'b01:   baud = 4800;
      2'b10:   baud = 9600;
      default: baud = 19200;
    endcase
    return (100_000_000 + baud * 16 / 2) / (baud * 16);
  endfunction

  // Counts rising edges until tick is seen high; limit+1 means it never came.
  task automatic wait_tick(input int limit, output int n);
    n = limit + 1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk);
      #1;
`ifdef BAUDGEN_BITTICK_EN
      if (bit_tick === 1'b1 && tick !== 1'b1) bt_stray++;
`endif
      if (tick === 1'b1) begin
        n = k;
`ifdef BAUDGEN_BITTICK_EN
        bt_at_tick = (bit_tick === 1'b1) ? 1 : 0;
`endif
        return;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    rstn = 1'b1;
    sel  = 2'b01;
    #1;
    total++;
    if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", tick); end
    #9;
    rstn = 1'b0;
    wait_tick(3000, n);
    total++;
    if (n != ref_div(2'b01)) begin bad++; $display("FAIL first_tick got=%0d want=%0d", n, ref_div(2'b01)); end
    @(posedge clk);
    #1;
    total++;
    if (tick !== 1'b0) begin bad++; $display("FAIL tick_width got=%b want=0", tick); end
    wait_tick(3000, n);
    total++;
    if (n != ref_div(2'b01) - 1) begin bad++; $display("FAIL second_tick got=%0d want=%0d", n, ref_div(2'b01) - 1); end
  endtask

  task automatic test_periods();
    int n;
    logic [1:0] order [3] = '{2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 3; i++) begin
      sel = order[i];
      wait_tick(6000, n);
      total++;
      if (n != ref_div(sel) + 1) begin bad++; $display("FAIL change_latency sel=%0d got=%0d want=%0d", sel, n, ref_div(sel) + 1); end
      for (int p = 0; p < 3; p++) begin
        wait_tick(6000, n);
        total++;
        if (n != ref_div(sel)) begin bad++; $display("FAIL period sel=%0d got=%0d want=%0d", sel, n, ref_div(sel)); end
      end
    end
  endtask

  task automatic test_switch_mid();
    int n;
    int r;
    int highs;
    sel = 2'b01;
    wait_tick(3000, n);
    total++;
    if (n != ref_div(2'b01) + 1) begin bad++; $display("FAIL switch_setup got=%0d want=%0d", n, ref_div(2'b01) + 1); end
    r = $urandom_range(100, 1200);
    highs = 0;
    repeat (r) begin
      @(posedge clk);
      #1;
      if (tick !== 1'b0) highs++;
    end
    sel = 2'b10;
    wait_tick(3000, n);
    total++;
    if (highs != 0 || n != ref_div(2'b10) + 1) begin
      bad++;
      $display("FAIL switch_mid after=%0d got=%0d early=%0d want=%0d early=0", r, n, highs, ref_div(2'b10) + 1);
    end
    wait_tick(3000, n);
    total++;
    if (n != ref_div(2'b10)) begin bad++; $display("FAIL switch_period got=%0d want=%0d", n, ref_div(2'b10)); end
  endtask

  task automatic test_reset_mid();
    int n;
    sel = 2'b01;
    wait_tick(3000, n);
    repeat (700) @(posedge clk);
    #2;
    rstn = 1'b1;
    #1;
    total++;
    if (tick !== 1'b0) begin bad++; $display("FAIL reset_mid_tick got=%b want=0", tick); end
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    wait_tick(3000, n);
    total++;
    if (n != ref_div(2'b01)) begin bad++; $display("FAIL reset_mid_restart got=%0d want=%0d", n, ref_div(2'b01)); end
    // tick is high right now; an asynchronous reset must drop it before the next edge
    rstn = 1'b1;
    #1;
    total++;
    if (tick !== 1'b0) begin bad++; $display("FAIL async_clear got=%b want=0", tick); end
    @(posedge clk);
    #1;
    rstn = 1'b0;
    wait_tick(3000, n);
    total++;
    if (n != ref_div(2'b01)) begin bad++; $display("FAIL async_restart got=%0d want=%0d", n, ref_div(2'b01)); end
  endtask

  task automatic test_hold_reset();
    int n;
    int highs;
    rstn  = 1'b1;
    highs = 0;
    repeat (5000) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 15) == 0) sel = 2'($urandom_range(0, 3));
      if (tick !== 1'b0) highs++;
    end
    total++;
    if (highs != 0) begin bad++; $display("FAIL hold_reset highs got=%0d want=0", highs); end
    sel  = 2'($urandom_range(0, 3));
    rstn = 1'b0;
    wait_tick(6000, n);
    total++;
    if (n != ref_div(sel)) begin bad++; $display("FAIL hold_release sel=%0d got=%0d want=%0d", sel, n, ref_div(sel)); end
  endtask

  task automatic test_random();
    int n;
    logic [1:0] s;
    for (int i = 0; i < 3; i++) begin
      s = 2'($urandom_range(0, 3));
      if (s == sel) s = s + 2'd1;
      sel = s;
      wait_tick(6000, n);
      total++;
      if (n != ref_div(s) + 1) begin bad++; $display("FAIL rand_latency sel=%0d got=%0d want=%0d", s, n, ref_div(s) + 1); end
      wait_tick(6000, n);
      total++;
      if (n != ref_div(s)) begin bad++; $display("FAIL rand_period sel=%0d got=%0d want=%0d", s, n, ref_div(s)); end
    end
  endtask

`ifdef BAUDGEN_BITTICK_EN
  task automatic test_bit_tick();
    int n;
    int sum;
    int early;
    if (sel == 2'b10) begin
      sel = 2'b11;
      wait_tick(6000, n);
    end
    sel = 2'b10;
    bt_stray = 0;
    for (int round = 0; round < 2; round++) begin
      sum   = 0;
      early = 0;
      for (int i = 1; i <= 16; i++) begin
        wait_tick(1000, n);
        sum += n;
        if (i < 16 && bt_at_tick != 0) early++;
      end
      total++;
      if (early != 0 || bt_at_tick != 1 || sum != 16 * ref_div(2'b10) + ((round == 0) ? 1 : 0)) begin
        bad++;
        $display("FAIL bit_tick round=%0d early=%0d at16=%0d edges=%0d want early=0 at16=1 edges=%0d",
                 round, early, bt_at_tick, sum, 16 * ref_div(2'b10) + ((round == 0) ? 1 : 0));
      end
    end
    total++;
    if (bt_stray != 0) begin bad++; $display("FAIL bit_tick_stray got=%0d want=0", bt_stray); end
  endtask
`endif

  initial begin
    test_reset();
    test_periods();
    test_switch_mid();
    test_reset_mid();
    test_hold_reset();
    test_random();
`ifdef BAUDGEN_BITTICK_EN
    test_bit_tick();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
